// File: rtl/leve_chk_pkg.sv
// Shared types for the LEVE lockstep commit checker.
package leve_chk_pkg;

    // Buffered commits are stored at the widest supported size; narrower
    // configurations zero-extend, so constant-zero upper bits get trimmed.
    localparam int unsigned XlenMax = 64;
    localparam int unsigned RwMax   = 8;

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StPass = 2'd1,
        StFail = 2'd2
    } chk_state_e;

    typedef enum logic [2:0] {
        FcNone   = 3'd0,
        FcPc     = 3'd1,
        FcRd     = 3'd2,
        FcWdata  = 3'd3,
        FcOvf    = 3'd4,
        FcLane   = 3'd5,
        FcTohost = 3'd6
    } fail_code_e;

    typedef struct packed {
        logic [XlenMax-1:0] pc;
        logic [RwMax-1:0]   rd;
        logic [XlenMax-1:0] wdata;
    } commit_t;

    localparam int unsigned CommitW = $bits(commit_t);

endpackage

// File: rtl/leve_chk_fifo.sv
// In-order commit buffer: up to NLANE pushes and one pop per cycle.
module leve_chk_fifo
    import leve_chk_pkg::*;
#(
    parameter int unsigned NLANE = 2,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         CLK,
    input  logic                         RSTn,
    input  logic [$clog2(NLANE+1)-1:0]   lane_cnt,
    input  logic                         push,
    input  logic                         pop,
    input  logic [NLANE*CommitW-1:0]     push_data,
    output logic                         fits,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CommitW-1:0]           head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    commit_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // Space is judged against the occupancy before this cycle's pop.
    assign fits  = CW'(lane_cnt) <= (CW'(DEPTH) - count_q);
    assign count = count_q;
    assign head  = mem[rd_ptr_q];

    // Write accepted lanes in lane order starting at the write pointer.
    always_ff @(posedge CLK) begin
        if (push) begin
            for (int l = 0; l < NLANE; l++) begin
                if (l < int'(lane_cnt)) begin
                    mem[wr_ptr_q + AW'(l)] <= push_data[l*CommitW +: CommitW];
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(lane_cnt);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (push ? CW'(lane_cnt) : CW'(0)) - (pop ? CW'(1) : CW'(0));
        end
    end

endmodule

// File: rtl/leve_commit_checker.sv
// Lockstep commit checker: buffers DUT retirements, compares against the
// reference stream and turns tohost writes into sticky PASS/FAIL status.
module leve_commit_checker
    import leve_chk_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NLANE = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned RW    = 5
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [NLANE-1:0]      DUT_VALID,
    input  logic [NLANE*XLEN-1:0] DUT_PC,
    input  logic [NLANE*RW-1:0]   DUT_RD,
    input  logic [NLANE*XLEN-1:0] DUT_WDATA,
    input  logic                  REF_VALID,
    output logic                  REF_READY,
    input  logic [XLEN-1:0]       REF_PC,
    input  logic [RW-1:0]         REF_RD,
    input  logic [XLEN-1:0]       REF_WDATA,
    input  logic                  TOHOST_WE,
    input  logic [31:0]           TOHOST_DATA,
    output logic                  DONE,
    output logic                  PASS,
    output logic                  FAIL,
    output logic [2:0]            FAIL_CODE,
    output logic [XLEN-1:0]       FAIL_PC,
    output logic [31:0]           RETIRE_CNT
);

    localparam int unsigned KW = $clog2(NLANE + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    chk_state_e               state_q, state_d;
    fail_code_e               fail_code_q, fail_code_d;
    fail_code_e               cmp_code;
    logic [XLEN-1:0]          fail_pc_q, fail_pc_d;
    logic [31:0]              retire_cnt_q;
    logic                     pend_q, pend_d;

    logic [KW-1:0]            lane_cnt;
    logic [NLANE-1:0]         therm;
    logic                     lane_ok;
    logic [NLANE*CommitW-1:0] push_data;
    logic                     fits;
    logic [CW-1:0]            count;
    logic [CW-1:0]            count_next;
    logic [CommitW-1:0]       head_bits;
    commit_t                  head;
    logic                     in_run;
    logic                     push;
    logic                     pop;
    logic                     mismatch;

    // Count valid lanes and require them to form a thermometer from lane 0.
    always_comb begin
        lane_cnt = '0;
        therm    = '0;
        for (int l = 0; l < NLANE; l++) begin
            lane_cnt = lane_cnt + KW'(DUT_VALID[l]);
        end
        for (int l = 0; l < NLANE; l++) begin
            therm[l] = (l < int'(lane_cnt));
        end
        lane_ok = (DUT_VALID == therm);
    end

    // Pack each lane into the buffer's commit layout.
    always_comb begin
        push_data = '0;
        for (int l = 0; l < NLANE; l++) begin
            push_data[l*CommitW +: CommitW] = {XlenMax'(DUT_PC[l*XLEN +: XLEN]),
                                               RwMax'(DUT_RD[l*RW +: RW]),
                                               XlenMax'(DUT_WDATA[l*XLEN +: XLEN])};
        end
    end

    leve_chk_fifo #(
        .NLANE (NLANE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .lane_cnt  (lane_cnt),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .fits      (fits),
        .count     (count),
        .head      (head_bits)
    );

    assign head       = head_bits;
    assign in_run     = (state_q == StRun);
    assign REF_READY  = in_run && (count != '0);
    assign pop        = REF_VALID && REF_READY;
    assign push       = in_run && lane_ok && fits && (lane_cnt != '0);
    assign count_next = count + (push ? CW'(lane_cnt) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    assign mismatch   = pop && (cmp_code != FcNone);

    // Compare the buffer head against the reference beat, PC first.
    always_comb begin
        cmp_code = FcNone;
        if (head.pc != XlenMax'(REF_PC)) begin
            cmp_code = FcPc;
        end else if (head.rd != RwMax'(REF_RD)) begin
            cmp_code = FcRd;
        end else if ((REF_RD != '0) && (head.wdata != XlenMax'(REF_WDATA))) begin
            cmp_code = FcWdata;
        end
    end

    // Resolve this cycle's events; only the highest-priority cause is kept.
    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        fail_pc_d   = fail_pc_q;
        pend_d      = pend_q;
        if (in_run) begin
            if (!lane_ok) begin
                state_d     = StFail;
                fail_code_d = FcLane;
                fail_pc_d   = DUT_PC[XLEN-1:0];
            end else if (!fits) begin
                state_d     = StFail;
                fail_code_d = FcOvf;
                fail_pc_d   = DUT_PC[XLEN-1:0];
            end else if (mismatch) begin
                state_d     = StFail;
                fail_code_d = cmp_code;
                fail_pc_d   = head.pc[XLEN-1:0];
            end else if (TOHOST_WE && (TOHOST_DATA != 32'd1)) begin
                state_d     = StFail;
                fail_code_d = FcTohost;
                fail_pc_d   = XLEN'(TOHOST_DATA >> 1);
            end else if ((TOHOST_WE || pend_q) && (count_next == '0)) begin
                state_d = StPass;
            end else if (TOHOST_WE) begin
                // Pass request waits until every buffered commit is checked.
                pend_d = 1'b1;
            end
        end
    end

    // Checker state, failure record and matched-commit counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= StRun;
            fail_code_q  <= FcNone;
            fail_pc_q    <= '0;
            pend_q       <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
            fail_pc_q   <= fail_pc_d;
            pend_q      <= pend_d;
            if (pop && (cmp_code == FcNone)) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
        end
    end

    assign DONE       = (state_q != StRun);
    assign PASS       = (state_q == StPass);
    assign FAIL       = (state_q == StFail);
    assign FAIL_CODE  = fail_code_q;
    assign FAIL_PC    = fail_pc_q;
    assign RETIRE_CNT = retire_cnt_q;

endmodule
